mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit beside the single-cycle MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU, and holds the HI/LO registers that MFHI/MFLO read.
- The core drives a start pulse with both operands, stalls on busy, and resumes on done.
- One clock domain; replaces any combinational multiplier in the core's ALU.

Parameters:
- XLEN, 32, operand and HI/LO width (even, >= 8).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  XLEN  multiplicand / dividend
- rt_val  in  XLEN  multiplier / divisor
- busy  out  1  operation in progress; core stalls
- done  out  1  one-cycle completion pulse
- hi  out  XLEN  HI register (product high half / remainder)
- lo  out  XLEN  LO register (product low half / quotient)
- div_by_zero  out  1  divisor was zero; valid with done, held until next accept

Behaviour:
- Interface is fixed: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: busy=0, done=0, hi=0, lo=0, div_by_zero=0, FSM=IDLE.
- FSM states:
  - IDLE: start=1 latches op, operand magnitudes and result signs. Goes to MUL (op[1]=0) or DIV (op[1]=1).
  - MUL: XLEN shift-add iterations on magnitudes, one per cycle, 2*XLEN-bit accumulator.
  - DIV: XLEN restoring shift-subtract iterations on magnitudes.
  - FIN: apply sign correction, write hi/lo, go to IDLE.
- Latency: start high in cycle n, then busy high in cycles n+1 .. n+XLEN+1, then done high for one cycle in n+XLEN+2. With XLEN=32, done is 34 cycles after start.
- hi/lo update only on the edge that raises done. They hold their value through the next operation until its done.
- Signed multiply: product negated when operand signs differ, full 2*XLEN result.
- Signed divide: quotient negated when operand signs differ; remainder takes the dividend's sign.
- Overflow: signed most-negative / -1 gives lo = most-negative, hi = 0.
- Divide by zero takes full latency, with lo = all ones and hi = rs_val unchanged. Sign correction is suppressed and div_by_zero=1.
- start while busy=1: ignored, no queueing. Operands are latched at accept, so later changes on rs_val/rt_val have no effect.
- start in the same cycle as done: accepted (FSM is IDLE by then), so operations run back to back.
- rst mid-operation: immediately returns to IDLE, clears hi/lo, and produces no done pulse.

Optional Feature:
- Macro: MULDIV_MTHI_MTLO_EN.
- Defined: adds ports mt_we (in, 1), mt_sel (in, 1; 0=LO, 1=HI) and mt_data (in, XLEN).
  - mt_we=1 while busy=0 writes the selected register on the next edge, and done stays 0.
  - mt_we while busy is ignored.
  - mt_we and start in the same cycle: start wins and mt_we is dropped.
- Undefined: ports absent; HI/LO change only via operations.

Decomposition:
- Package mips_muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enum (IDLE, MUL, DIV, FIN).
- One sub-module: mips_muldiv_signfix, combinational magnitude/negate helper instantiated for the operands at accept and for the results at FIN.
- Iteration datapath stays in the top module.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start; busy high 33 cycles.
- MULT -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1; following DIVU 9/3 -> div_by_zero=0, lo=3, hi=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start pulse at cycle 5 of a busy op is ignored (single done, original result). rst at cycle 10 of an op -> busy=0, hi=lo=0 next cycle, no done pulse.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation encodings and FSM states.
package mips_muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/mips_muldiv_signfix.sv
// Conditional two's-complement negate: yields a magnitude from a signed operand,
// or re-applies a sign to an unsigned result.
module mips_muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; one iteration per clock.
// Optional MTHI/MTLO write port enabled by defining MULDIV_MTHI_MTLO_EN.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
`ifdef MULDIV_MTHI_MTLO_EN
    input  logic            mt_we,
    input  logic            mt_sel,
    input  logic [XLEN-1:0] mt_data,
`endif
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero,
    output state_e          dbg_state
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    state_e            r_state, w_next;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div, r_neg_q, r_neg_r, r_dbz_pend;
    logic              r_done, r_dbz;
    logic [XLEN-1:0]   r_hi, r_lo;

    logic              w_signed, w_rs_neg, w_rt_neg, w_dbz;
    logic [XLEN-1:0]   w_rs_mag, w_rt_mag, w_quo, w_rem;
    logic [2*XLEN-1:0] w_prod, w_mul_next, w_div_next;
    logic [XLEN:0]     w_sum, w_trial;
    logic              w_ge;

    assign w_signed = ~op[0];
    assign w_rs_neg = w_signed & rs_val[XLEN-1];
    assign w_rt_neg = w_signed & rt_val[XLEN-1];
    assign w_dbz    = op[1] & (rt_val == '0);

    // On a zero divisor the raw dividend is iterated so the remainder comes out as rs_val.
    mips_muldiv_signfix #(.W(XLEN)) u_rs_mag (.i_val(rs_val), .i_neg(w_rs_neg & ~w_dbz), .o_val(w_rs_mag));
    mips_muldiv_signfix #(.W(XLEN)) u_rt_mag (.i_val(rt_val), .i_neg(w_rt_neg), .o_val(w_rt_mag));

    mips_muldiv_signfix #(.W(2*XLEN)) u_prod (.i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod));
    mips_muldiv_signfix #(.W(XLEN)) u_quo (.i_val(r_acc[XLEN-1:0]), .i_neg(r_neg_q), .o_val(w_quo));
    mips_muldiv_signfix #(.W(XLEN)) u_rem (.i_val(r_acc[2*XLEN-1:XLEN]), .i_neg(r_neg_r), .o_val(w_rem));

    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_b : '0)};
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Restoring divide: {remainder, quotient} shifts left, quotient bit enters at the LSB.
    assign w_trial    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    assign w_ge       = ~w_trial[XLEN];
    assign w_div_next = {(w_ge ? w_trial[XLEN-1:0] : r_acc[2*XLEN-2:XLEN-1]), r_acc[XLEN-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = op[1] ? DIV : MUL;
            MUL:     if (r_cnt == '0) w_next = FIN;
            DIV:     if (r_cnt == '0) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc      <= {{XLEN{1'b0}}, (op[1] ? w_rs_mag : w_rt_mag)};
                        r_b        <= op[1] ? w_rt_mag : w_rs_mag;
                        r_cnt      <= CW'(XLEN-1);
                        r_is_div   <= op[1];
                        r_neg_q    <= (w_rs_neg ^ w_rt_neg) & ~w_dbz;
                        r_neg_r    <= w_rs_neg & op[1] & ~w_dbz;
                        r_dbz_pend <= w_dbz;
                        r_dbz      <= 1'b0;
                    end
`ifdef MULDIV_MTHI_MTLO_EN
                    else if (mt_we) begin
                        if (mt_sel) r_hi <= mt_data;
                        else        r_lo <= mt_data;
                    end
`endif
                end
                MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                FIN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done <= 1'b1;
                    r_dbz  <= r_dbz_pend;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    state_e      dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
`ifdef MULDIV_MTHI_MTLO_EN
        .mt_we(1'b0), .mt_sel(1'b0), .mt_data(32'h0),
`endif
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero), .dbg_state(dbg_state)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit / signed integer arithmetic plus the two special cases.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] m_hi, output logic [31:0] m_lo, output logic m_dbz);
        longint p;
        int sa, sb;
        m_dbz = 1'b0;
        sa = a;
        sb = b;
        case (o)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                {m_hi, m_lo} = p;
            end
            OP_MULTU: {m_hi, m_lo} = {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a; m_dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = '0;
                end else begin
                    m_lo = sa / sb; m_hi = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a; m_dbz = 1'b1;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
        endcase
    endtask

    // Leaves the bench at the negedge of the done cycle (unless inject, which steps one more).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit b2b, input bit inject, input string tag);
        logic [31:0] m_hi, m_lo;
        logic m_dbz;
        int cycles, busy_cnt;
        model(o, a, b, m_hi, m_lo, m_dbz);
        if (!b2b) @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        rs_val = $urandom; rt_val = $urandom; op = 2'($urandom_range(0, 3));
        cycles = 1; busy_cnt = 0;
        while (!done && cycles < 60) begin
            if (busy) busy_cnt++;
            if (inject) start = (cycles == 5);
            if (cycles == 10) begin
                check_eq({tag, "_hold_hi"}, {32'h0, hi}, {32'h0, exp_hi});
                check_eq({tag, "_hold_lo"}, {32'h0, lo}, {32'h0, exp_lo});
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 64'(cycles), 64'd34);
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check_eq({tag, "_hi"}, {32'h0, hi}, {32'h0, m_hi});
        check_eq({tag, "_lo"}, {32'h0, lo}, {32'h0, m_lo});
        check_eq({tag, "_dbz"}, {63'h0, div_by_zero}, {63'h0, m_dbz});
        exp_hi = m_hi; exp_lo = m_lo;
        if (inject) begin
            @(negedge clk);
            check_eq({tag, "_no_second_done"}, {63'h0, done}, 64'h0);
            check_eq({tag, "_idle_after"}, {63'h0, busy}, 64'h0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit no_done;
        bit at_done;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_busy", {63'h0, busy}, 64'h0);
        check_eq("reset_done", {63'h0, done}, 64'h0);
        check_eq("reset_hi", {32'h0, hi}, 64'h0);
        check_eq("reset_lo", {32'h0, lo}, 64'h0);
        check_eq("reset_dbz", {63'h0, div_by_zero}, 64'h0);

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        check_eq("multu_max_hi_const", {32'h0, hi}, 64'hFFFF_FFFE);
        check_eq("multu_max_lo_const", {32'h0, lo}, 64'h0000_0001);
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, "mult_neg");
        check_eq("mult_neg_lo_const", {32'h0, lo}, 64'hFFFF_FFEB);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg");
        check_eq("div_neg_hi_const", {32'h0, hi}, 64'hFFFF_FFFF);
        check_eq("div_neg_lo_const", {32'h0, lo}, 64'hFFFF_FFFD);
        do_op(OP_DIVU, 32'd100, 32'd7, 0, 0, "divu_100_7");
        do_op(OP_DIVU, 32'd100, 32'd0, 0, 0, "divu_by0");
        check_eq("divu_by0_lo_const", {32'h0, lo}, 64'hFFFF_FFFF);
        do_op(OP_DIVU, 32'd9, 32'd3, 0, 0, "divu_9_3");
        do_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1, 0, "div_neg_by0_b2b");
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "div_ovf_b2b");
        check_eq("div_ovf_lo_const", {32'h0, lo}, 64'h8000_0000);
        do_op(OP_MULT, 32'd1234, 32'd5678, 0, 1, "ignored_start");

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_mid_hi", {32'h0, hi}, 64'h0);
        check_eq("rst_mid_lo", {32'h0, lo}, 64'h0);
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        check_eq("rst_mid_no_done", {63'h0, no_done}, 64'h1);
        exp_hi = '0; exp_lo = '0;

        at_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bit b2b;
            b2b = at_done && ($urandom_range(0, 1) == 1);
            do_op(2'($urandom_range(0, 3)), pick(), pick(), b2b, 0, $sformatf("rnd%0d", i));
            at_done = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
